// File: rtl/stream_mux_arb.sv
// stream_mux_arb: NCH-channel valid/ready stream multiplexer.
// Chooses one input by fixed-priority or round-robin arbitration and can hold the grant
// for a whole packet. The winning word passes through one registered output stage that
// streams at one word per clock.
module stream_mux_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = $clog2(NCH),
    parameter int unsigned RR    = 1,
    parameter int unsigned LOCK  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_last,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [SELW-1:0] lock_ch_q, lock_ch_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [SELW-1:0]  sel_q, sel_d;

    logic             load;
    logic             arb_found;
    logic [SELW-1:0]  arb_idx;
    int unsigned      scan_idx;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic             xfer;
    logic             xfer_last;
    logic [WIDTH-1:0] gnt_word;

    // Output stage can take a new word when empty or being popped this cycle
    assign load = ~valid_q | out_ready;

    // Free arbitration: scan from rr_ptr (round-robin) or from channel 0 (fixed priority)
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            scan_idx = (RR != 0) ? ((32'(rr_ptr_q) + k) % NCH) : k;
            if (!arb_found && in_valid[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = SELW'(scan_idx);
            end
        end
    end

    // Grant output: locked channel overrides arbitration, even when it has no data
    always_comb begin
        gnt_idx   = arb_idx;
        gnt_valid = load & arb_found;
        if (LOCK != 0 && state_q == StLocked) begin
            gnt_idx   = lock_ch_q;
            gnt_valid = load;
        end
        if (reset) begin
            gnt_valid = 1'b0;
        end
        in_ready = gnt_valid ? ({{(NCH-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    end

    assign xfer      = |(in_valid & in_ready);
    assign xfer_last = in_last[gnt_idx];
    assign gnt_word  = in_data[gnt_idx*WIDTH +: WIDTH];

    // Packet-lock FSM next state; never leaves StIdle when locking is disabled
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        if (LOCK != 0 && xfer) begin
            unique case (state_q)
                StIdle: begin
                    if (!xfer_last) begin
                        state_d   = StLocked;
                        lock_ch_d = gnt_idx;
                    end
                end
                StLocked: begin
                    if (xfer_last) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Round-robin pointer moves past the winner; with locking only at packet end
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (RR != 0 && xfer && (LOCK == 0 || xfer_last)) begin
            rr_ptr_d = (32'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + SELW'(1);
        end
    end

    // Output stage next state: load on transfer, drain on idle load, hold under backpressure
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        sel_d   = sel_q;
        if (load) begin
            valid_d = xfer;
            if (xfer) begin
                data_d = gnt_word;
                last_d = xfer_last;
                sel_d  = gnt_idx;
            end
        end
    end

    // Control state register; reset abandons any packet in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Output data register
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_sel   = sel_q;

    // Grant invariants
    assert property (@(posedge clk) disable iff (reset) $onehot0(in_ready));
    assert property (@(posedge clk) disable iff (reset) !((|in_ready) && !load));
    assert property (@(posedge clk) disable iff (reset) 32'(out_sel) < NCH);

endmodule
